// File: rtl/encoded_memory_sequencer_pkg.sv
// rtl/encoded_memory_sequencer_pkg.sv - shared state encoding, default sizes and memory mode codes
package encoded_memory_sequencer_pkg;

    localparam int P_DATA_W = 8;
    localparam int P_DEPTH  = 8;
    localparam int P_ADDR_W = 3;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        READ = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/encoded_memory_sequencer.sv
// rtl/encoded_memory_sequencer.sv - burst load, read-back and streaming sequencer for EncodedMemory
module encoded_memory_sequencer
    import encoded_memory_sequencer_pkg::*;
#(
    parameter int DATA_W = P_DATA_W,
    parameter int DEPTH  = P_DEPTH,
    parameter int ADDR_W = P_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_index,
    output logic [DATA_W-1:0] mem_number,
    input  logic [DATA_W-1:0] mem_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W+2:0] sum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W+2:0] sum_q;
    logic              at_last;

    assign at_last    = (idx_q == LAST_IDX);
    assign mem_index  = idx_q;
    assign mem_number = in_data;
    assign out_data   = out_data_q;
    assign sum        = sum_q;

    // Next-state and handshake/strobe decode; memory only writes while a byte is offered in LOAD
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mem_mode  = MODE_READ;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_mode = MODE_WRITE;
                    if (at_last) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = at_last;
                if (out_ready) begin
                    state_d = at_last ? DONE : READ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Index counter, read-back capture and running sum of accepted words
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q      <= '0;
            out_data_q <= '0;
            sum_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q <= '0;
                        sum_q <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        idx_q <= at_last ? '0 : idx_q + 1'b1;
                    end
                end
                READ: begin
                    out_data_q <= mem_result;
                end
                SEND: begin
                    if (out_ready) begin
                        sum_q <= sum_q + (DATA_W + 3)'(out_data_q);
                        if (!at_last) begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoded_memory_sequencer.sv
// tb/tb_encoded_memory_sequencer.sv - scoreboard bench for encoded_memory_sequencer with EncodedMemory model
module tb_encoded_memory_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_mode;
    logic [2:0]  mem_index;
    logic [7:0]  mem_number;
    logic [7:0]  mem_result;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [10:0] sum;

    always #5 CLK = ~CLK;

    encoded_memory_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_mode   (mem_mode),
        .mem_index  (mem_index),
        .mem_number (mem_number),
        .mem_result (mem_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .sum        (sum)
    );

    // EncodedMemory: stores |number - mask[index]|, no reset, combinational read
    logic [7:0] mask [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};
    logic [7:0] mem_q [8] = '{default: 8'h00};

    function automatic logic [7:0] enc(input logic [7:0] num, input int i);
        int a;
        a = int'(num) - int'(mask[i]);
        if (a < 0) a = -a;
        return 8'(a);
    endfunction

    always @(posedge CLK) begin
        if (mem_mode == 1'b0) mem_q[mem_index] <= enc(mem_number, int'(mem_index));
    end
    assign mem_result = mem_q[mem_index];

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   exp_sum = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   word_cnt = 0;
    int   ready_mode = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Consumer: always ready, random, or a 5-cycle stall on the third word
    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid && word_cnt == 2 && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: pops the scoreboard on every accepted word and checks stall stability and done
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [10:0] prev_sum = 11'h0;
    always @(negedge CLK) begin
        if (!RST) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_sum", 32'(sum), 32'(prev_sum));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
                word_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("done_sum", 32'(sum), 32'(exp_sum));
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_sum   = sum;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_mem_mode"}, 32'(mem_mode), 32'd1);
        chk({tag, "_mem_index"}, 32'(mem_index), 32'd0);
    endtask

    // Start pulse with a byte offered in the same cycle; that byte must not be consumed
    task automatic start_burst();
        @(posedge CLK); #1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        exp_sum  = 0;
        word_cnt = 0;
        stall_cnt = 0;
        @(negedge CLK);
        chk("start_in_ready", 32'(in_ready), 32'd0);
        chk("start_mem_mode", 32'(mem_mode), 32'd1);
        @(posedge CLK); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    // Offer n bytes; gap 0 = back to back, 1 = every other cycle, 2 = random
    task automatic load_bytes(input logic [7:0] d [8], input int n, input int gap);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 200) begin
            @(posedge CLK); #1;
            case (gap)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 1);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? d[k] : 8'($urandom);
            @(negedge CLK);
            chk("load_mem_mode", 32'(mem_mode), 32'(!in_valid));
            if (in_valid && in_ready) begin
                exp_t e;
                e.data = enc(d[k], k);
                e.last = (k == 7);
                exp_q.push_back(e);
                exp_sum += int'(e.data);
                k++;
            end
            cyc++;
        end
        chk("load_timeout", 32'(k), 32'(n));
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int c = 0;
        while (done_cnt == d0 && c < 400) begin
            @(posedge CLK);
            c++;
        end
        chk("done_timeout", 32'(done_cnt != d0), 32'd1);
        repeat (3) @(negedge CLK);
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("sum_hold", 32'(sum), 32'(exp_sum));
    endtask

    task automatic run_burst(input logic [7:0] d [8], input int gap, input int rmode);
        ready_mode = rmode;
        start_burst();
        load_bytes(d, 8, gap);
        wait_done();
    endtask

    logic [7:0] data [8];

    initial begin
        // Reset state
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset mid-way through LOAD after 3 writes
        ready_mode = 0;
        for (int i = 0; i < 8; i++) data[i] = 8'($urandom);
        start_burst();
        load_bytes(data, 3, 0);
        #3 RST = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge CLK); #1 RST = 1'b0;

        // All 0x80, consumer always ready
        for (int i = 0; i < 8; i++) data[i] = 8'h80;
        run_burst(data, 0, 0);
        chk("sum_0x80", 32'(sum), 32'd718);

        // Ramp 0..7 with in_valid gaps every other cycle
        for (int i = 0; i < 8; i++) data[i] = 8'(i);
        run_burst(data, 1, 0);

        // Consumer stalls for 5 cycles on word 2
        for (int i = 0; i < 8; i++) data[i] = 8'($urandom);
        run_burst(data, 0, 2);
        chk("stall_cycles", 32'(stall_cnt), 32'd5);

        // start pulse during SEND is ignored
        for (int i = 0; i < 8; i++) data[i] = 8'($urandom);
        ready_mode = 0;
        start_burst();
        load_bytes(data, 8, 0);
        begin
            int c = 0;
            while (!out_valid && c < 50) begin
                @(negedge CLK);
                c++;
            end
            chk("send_reached", 32'(out_valid), 32'd1);
        end
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
        wait_done();
        repeat (4) @(negedge CLK);
        chk("no_restart", 32'(busy), 32'd0);

        // Randomized bursts: random data, random valid gaps, random consumer
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) data[i] = 8'($urandom);
            run_burst(data, 2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
